// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer
module multicycle_sequencer #(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] target_addr,
  input  logic            branch_taken,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] pc,
  output logic            alu_en,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic            illegal,
  output logic [31:0]     instret,
  output logic [2:0]      state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [2:0]      next_state;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] pc_plus4;
  logic            boot;      // first cycle after reset: fetch request held low
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            is_jump;
  logic            is_store;
  logic            legal;
  logic            fetch_done;

  assign opcode     = ir[6:0];
  assign funct7     = ir[31:25];
  assign rd         = ir[11:7];
  assign is_jump    = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_store   = (opcode == OP_S);
  assign pc_plus4   = pc + XLEN'(4);
  assign imem_addr  = pc;
  assign fetch_done = !boot && imem_ready;

  // opcode / funct7 legality check used in DECODE
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                       (funct7 == 7'b0000001);
      OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_JAL, OP_JALR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (fetch_done) next_state = S_DECODE;
      S_DECODE: next_state = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (opcode == OP_B)                         next_state = S_FETCH;
        else if (opcode == OP_LOAD || is_store)     next_state = S_MEM;
        else                                        next_state = S_WB;
      end
      S_MEM:    if (dmem_ready) next_state = is_store ? S_FETCH : S_WB;
      S_WB:     next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  // architectural registers: pc, ir, retire count, sticky illegal, jump target
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      target_q <= '0;
      boot     <= 1'b1;
    end else begin
      boot <= 1'b0;
      case (state)
        S_FETCH:  if (fetch_done) ir <= imem_rdata;
        S_DECODE: if (!legal) illegal <= 1'b1;
        S_EXEC: begin
          if (opcode == OP_B) begin
            pc      <= branch_taken ? target_addr : pc_plus4;
            instret <= instret + 32'd1;
          end
          if (is_jump) target_q <= target_addr;
        end
        S_MEM: begin
          if (dmem_ready && is_store) begin
            pc      <= pc_plus4;
            instret <= instret + 32'd1;
          end
        end
        S_WB: begin
          pc      <= is_jump ? target_q : pc_plus4;
          instret <= instret + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // strobes decoded from registered state only
  always_comb begin
    imem_req = (state == S_FETCH) && !boot;
    dmem_req = (state == S_MEM);
    dmem_we  = (state == S_MEM) && is_store;
    alu_en   = (state == S_EXEC);
    reg_we   = (state == S_WB) && (rd != 5'd0);
    wb_sel   = 2'd0;
    if (state == S_WB) begin
      if (opcode == OP_LUI)       wb_sel = 2'd3;
      else if (is_jump)           wb_sel = 2'd2;
      else if (opcode == OP_LOAD) wb_sel = 2'd1;
      else                        wb_sel = 2'd0;
    end
  end

endmodule
